// File: rtl/freq_ctrl_pkg.sv
// Shared types and helpers for the frequency-select switch controller.
package freq_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH_SEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among asserted requests, searching from
// one past the most recently granted requester.
module rr_arbiter
  import freq_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Priority search starting one past the last granted requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; reset value makes requester 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/freq_switch_ctrl.sv
// Shares the divider's fsel among requesters; applies a new select only on a
// fout falling edge, then waits a number of fout periods before reporting done.
module freq_switch_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter  int unsigned          WIDTH_SEL      = DEFAULT_WIDTH_SEL,
  parameter  int unsigned          NUM_REQ        = 2,
  parameter  int unsigned          SETTLE_PERIODS = 2,
  parameter  int unsigned          TIMEOUT_CYCLES = 256,
  parameter  logic [WIDTH_SEL-1:0] RESET_FSEL     = '0,
  localparam int unsigned          ID_W           = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH_SEL-1:0] req_fsel,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fout,
  output logic [WIDTH_SEL-1:0]         fsel_out,
  output logic                         busy,
  output logic                         done,
  output logic [ID_W-1:0]              done_id,
  output logic                         timeout
);

  localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES);
  localparam int unsigned PER_W = clog2(SETTLE_PERIODS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SETTLE_PERIODS);

  state_t                 state, state_n;
  logic                   fout_q, fall, accept;
  logic [CNT_W-1:0]       cyc_cnt, cyc_cnt_n;
  logic [PER_W-1:0]       per_cnt, per_cnt_n, per_inc;
  logic [WIDTH_SEL-1:0]   code_q, code_n, fsel_n, sel_code;
  logic [ID_W-1:0]        id_q, id_n;
  logic                   to_flag, to_flag_n;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;

  assign fall     = fout_q & ~fout;
  // Reset also masks the grant so nothing is accepted while RST is high.
  assign accept   = (state == ST_IDLE) && !RST && (|req_valid);
  assign sel_code = req_fsel[32'(grant_id) * WIDTH_SEL +: WIDTH_SEL];
  assign per_inc  = PER_W'(per_cnt + 1'b1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (RST),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Next-state, counter and select decisions.
  always_comb begin
    state_n   = state;
    cyc_cnt_n = cyc_cnt;
    per_cnt_n = per_cnt;
    code_n    = code_q;
    id_n      = id_q;
    fsel_n    = fsel_out;
    to_flag_n = to_flag;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          code_n = sel_code;
          id_n   = grant_id;
          if (sel_code == fsel_out) begin
            state_n = ST_DONE;
          end else begin
            state_n   = ST_WAIT_EDGE;
            cyc_cnt_n = '0;
          end
        end
      end
      ST_WAIT_EDGE: begin
        if (fall || cyc_cnt == CNT_LAST) begin
          fsel_n    = code_q;
          to_flag_n = to_flag | ~fall;
          per_cnt_n = '0;
          cyc_cnt_n = '0;
          state_n   = ST_SETTLE;
        end else begin
          cyc_cnt_n = cyc_cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (fall) begin
          per_cnt_n = per_inc;
          cyc_cnt_n = '0;
          if (per_inc == PER_LAST) state_n = ST_DONE;
        end else if (cyc_cnt == CNT_LAST) begin
          to_flag_n = 1'b1;
          state_n   = ST_DONE;
        end else begin
          cyc_cnt_n = cyc_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        to_flag_n = 1'b0;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters, captured request and the select register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= ST_IDLE;
      fout_q   <= 1'b0;
      cyc_cnt  <= '0;
      per_cnt  <= '0;
      code_q   <= '0;
      id_q     <= '0;
      fsel_out <= RESET_FSEL;
      to_flag  <= 1'b0;
    end else begin
      state    <= state_n;
      fout_q   <= fout;
      cyc_cnt  <= cyc_cnt_n;
      per_cnt  <= per_cnt_n;
      code_q   <= code_n;
      id_q     <= id_n;
      fsel_out <= fsel_n;
      to_flag  <= to_flag_n;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign timeout   = done & to_flag;
  assign done_id   = id_q;
  assign req_ready = accept ? grant : '0;

endmodule

// File: tb/tb_freq_switch_ctrl.sv
// Randomized bench: fout waveform is generated up front so each accepted
// request's apply/done cycles can be predicted by scanning for falling edges.
module tb_freq_switch_ctrl;

  localparam int unsigned W    = 3;
  localparam int unsigned N    = 3;
  localparam int unsigned SP   = 2;
  localparam int unsigned TO   = 16;
  localparam logic [W-1:0] RF  = 3'd0;
  localparam int NCYC          = 4000;
  localparam int FLEN          = NCYC + 200;

  logic               clk = 1'b0;
  logic               RST;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_fsel;
  logic [N-1:0]       req_ready;
  logic               fout;
  logic [W-1:0]       fsel_out;
  logic               busy, done, timeout;
  logic [1:0]         done_id;

  always #5 clk = ~clk;

  freq_switch_ctrl #(
    .WIDTH_SEL      (W),
    .NUM_REQ        (N),
    .SETTLE_PERIODS (SP),
    .TIMEOUT_CYCLES (TO),
    .RESET_FSEL     (RF)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_fsel  (req_fsel),
    .req_ready (req_ready),
    .fout      (fout),
    .fsel_out  (fsel_out),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .timeout   (timeout)
  );

  bit F [FLEN];
  bit R [FLEN];
  int cyc;
  int unsigned checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Falling edge of fout as seen by the controller during cycle c.
  function automatic bit fall_at(input int c);
    if (c <= 0 || c >= FLEN) return 1'b0;
    return !R[c-1] && F[c-1] && !F[c];
  endfunction

  function automatic int winner(input logic [N-1:0] vv, input int lst);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (lst + k) % N;
      if (vv[i]) return i;
    end
    return -1;
  endfunction

  // First edge within a timeout window applies the code (else forced), then
  // SP more edges each within a fresh window (else forced done).
  task automatic plan(input int t, output int a, output int d, output bit fl);
    int p;
    bit found;
    fl = 1'b0;
    found = 1'b0;
    a = t + 1 + TO;
    for (int c = t + 1; c < t + 1 + TO; c++)
      if (!found && fall_at(c)) begin a = c + 1; found = 1'b1; end
    if (!found) fl = 1'b1;
    p = a;
    for (int k = 0; k < SP; k++) begin
      found = 1'b0;
      for (int c = p; c < p + TO; c++)
        if (!found && fall_at(c)) begin p = c + 1; found = 1'b1; end
      if (!found) begin p = p + TO; fl = 1'b1; break; end
    end
    d = p;
  endtask

  bit           active, m_flag;
  int           a_cyc, d_cyc, m_id, last, last_rst, win;
  logic [W-1:0] m_cur, old_code, new_code;
  logic [N-1:0] v, exp_ready;
  logic [W-1:0] code [N];
  int unsigned  n_noop, n_switch, n_to, n_rst_mid;

  initial begin
    int p, len, half;
    bit val;
    for (int i = 0; i < 5; i++) F[i] = 1'b1;
    for (int i = 5; i < 12; i++) F[i] = 1'b0;
    p = 12;
    while (p < FLEN) begin
      val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        len = $urandom_range(17, 40);
        for (int j = 0; j < len; j++) if (p < FLEN) begin F[p] = val; p++; end
      end else begin
        half = $urandom_range(1, 6);
        len  = $urandom_range(10, 60);
        for (int j = 0; j < len; j++) begin
          if (p < FLEN) begin F[p] = val; p++; end
          if ((j + 1) % half == 0) val = ~val;
        end
      end
    end
    for (int i = 0; i < 3; i++) R[i] = 1'b1;

    active = 1'b0; m_flag = 1'b0; m_cur = RF; last = N - 1; last_rst = 0;
    a_cyc = 0; d_cyc = 0; m_id = 0; old_code = RF; new_code = RF;
    n_noop = 0; n_switch = 0; n_to = 0; n_rst_mid = 0;
    v = '0;
    for (int i = 0; i < N; i++) code[i] = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && active && cyc >= a_cyc && cyc < d_cyc &&
          cyc - last_rst > 40 && $urandom_range(0, 19) == 0) begin
        R[cyc] = 1'b1;
        last_rst = cyc;
        n_rst_mid++;
      end
      if (cyc >= 10)
        for (int i = 0; i < N; i++)
          if (!v[i] && $urandom_range(0, 3) == 0) begin
            v[i] = 1'b1;
            code[i] = ($urandom_range(0, 3) == 0) ? m_cur : W'($urandom);
          end
      RST       = R[cyc];
      fout      = F[cyc];
      req_valid = v;
      for (int i = 0; i < N; i++) req_fsel[i*W +: W] = code[i];
      #1;

      win = (R[cyc] || active) ? -1 : winner(v, last);
      exp_ready = (win >= 0) ? N'(1 << win) : '0;
      if (cyc >= 1) begin
        check("busy", 32'(busy), 32'(active));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("done", 32'(done), 32'(active && cyc == d_cyc));
        check("timeout", 32'(timeout), 32'(active && cyc == d_cyc && m_flag));
        check("fsel_out", 32'(fsel_out), 32'((active && cyc >= a_cyc) ? new_code : m_cur));
        if (active && cyc == d_cyc) check("done_id", 32'(done_id), 32'(m_id));
        if (cyc <= 3) check("reset_done_id", 32'(done_id), 32'd0);
      end

      if (R[cyc]) begin
        active = 1'b0; m_cur = RF; last = N - 1;
      end else if (active) begin
        if (cyc == d_cyc) begin
          active = 1'b0;
          m_cur = new_code;
          if (m_flag) n_to++;
        end
      end else if (win >= 0) begin
        v[win]   = 1'b0;
        m_id     = win;
        last     = win;
        old_code = m_cur;
        new_code = code[win];
        active   = 1'b1;
        if (new_code == old_code) begin
          a_cyc = cyc + 1; d_cyc = cyc + 1; m_flag = 1'b0;
          n_noop++;
        end else begin
          plan(cyc, a_cyc, d_cyc, m_flag);
          n_switch++;
        end
      end
    end

    check("seen_noop", 32'(n_noop > 0), 32'd1);
    check("seen_switch", 32'(n_switch > 0), 32'd1);
    check("seen_timeout", 32'(n_to > 0), 32'd1);
    check("seen_reset_mid_op", 32'(n_rst_mid > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
